// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux channel arbiter/multiplexer.
// Grant policy codes and the select-width computation live here.
package arb_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Select width never collapses below one bit, even for tiny channel counts.
    function automatic int calc_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr,
// wrapping from the top channel back to channel 0.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = calc_sel_w(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_valid
);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = NUM_IN; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_IN]) begin
                grant       = SEL_W'((int'(ptr) + k) % NUM_IN);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 valid/ready multiplexer with a single-entry registered output stage.
// Grant comes from an external select or from a round-robin pointer.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int  WIDTH  = 32,
    parameter int  NUM_IN = 4,
    parameter int  MODE   = MODE_SEL,
    localparam int SEL_W  = calc_sel_w(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] chan_data [NUM_IN];
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load_en;
    logic             transfer;

    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_chan_reg;
    logic             out_valid_reg;

    assign load_en = !out_valid_reg || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] rr_ptr_reg;
            logic             unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter #(
                .NUM_IN (NUM_IN),
                .SEL_W  (SEL_W)
            ) u_rr_arbiter (
                .req         (in_valid),
                .ptr         (rr_ptr_reg),
                .grant       (grant),
                .grant_valid (grant_valid)
            );

            // Resetting to the top channel makes channel 0 the first winner.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_ptr_reg <= SEL_W'(NUM_IN - 1);
                end else if (transfer) begin
                    rr_ptr_reg <= grant;
                end
            end
        end else begin : g_sel
            // Unknown or out-of-range selects fall back to channel 0.
            always_comb begin
                grant = sel;
                if ((^sel === 1'bx) || (int'(sel) >= NUM_IN)) begin
                    grant = '0;
                end
            end

            assign grant_valid = in_valid[grant];
        end
    endgenerate

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
        assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        // Gating with rst_n keeps every ready low for the whole reset window.
        assign in_ready[gi]  = rst_n && load_en && grant_valid &&
                               (grant == SEL_W'(gi)) && in_valid[gi];
    end

    assign transfer = |in_ready;

    // A drain without a new word clears valid but keeps the last data/channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
        end else if (load_en) begin
            out_valid_reg <= transfer;
            if (transfer) begin
                out_data_reg <= chan_data[grant];
                out_chan_reg <= grant;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign out_valid = out_valid_reg;

endmodule
